// File: rtl/gmii_to_axis_rx_pkg.sv
// Shared definitions for the GMII receive to AXI-Stream converter: tag bit
// positions, SFD value, lane count, rx state encoding and keep helper.
package gmii_axis_pkg;

    localparam int TAG_SOP = 0;
    localparam int TAG_EOP = 1;
    localparam int TAG_ERR = 2;

    localparam logic [7:0] GMII_SFD = 8'hD5;
    localparam int PAYLOAD_LANES = 7;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRE         = 3'd1,
        DATA        = 3'd2,
        DROP        = 3'd3,
        DROP_SILENT = 3'd4
    } rx_state_e;

    // Keep mask for a word holding k payload bytes: tag lane plus lanes 1..k.
    function automatic logic [7:0] lane_keep(input logic [2:0] k);
        return 8'hFF >> (3'd7 - k);
    endfunction

endpackage

// File: rtl/gmii_to_axis_rx_if.sv
// GMII receive inputs and AXI-Stream outputs of the converter, bundled.
// slave is the converter's view, master is the view of whoever drives GMII and consumes beats.
interface gmii_to_axis_rx_if;

    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  gmii_rxd;

    // axis_tvalid is a one-cycle pulse per beat; there is no tready, the sink must always accept.
    logic        axis_tvalid;
    logic [63:0] axis_tdata;
    logic [7:0]  axis_tkeep;
    logic        axis_tlast;

    modport master (
        output gmii_rx_dv, gmii_rx_er, gmii_rxd,
        input  axis_tvalid, axis_tdata, axis_tkeep, axis_tlast
    );

    modport slave (
        input  gmii_rx_dv, gmii_rx_er, gmii_rxd,
        output axis_tvalid, axis_tdata, axis_tkeep, axis_tlast
    );

endinterface

// File: rtl/gmii_to_axis_rx_packer.sv
// Byte packer: fills lanes 1..7 of an assembly word, parks full words in a
// holding register and hands out either the pending or the partial word.
module gmii_rx_byte_packer
    import gmii_axis_pkg::*;
(
    input  logic        gmii_rx_clk,
    input  logic        rst_n,
    input  logic        wr_en_i,
    input  logic [7:0]  wr_byte_i,
    input  logic        flush_i,
    output logic        emit_o,
    output logic [55:0] emit_data_o,
    output logic [7:0]  emit_keep_o
);

    logic [2:0]  ptr_q,  ptr_d;
    logic [55:0] asm_q,  asm_d;
    logic [55:0] hold_q, hold_d;
    logic        pend_q, pend_d;

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= 3'd0;
            asm_q  <= 56'h0;
            hold_q <= 56'h0;
            pend_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            asm_q  <= asm_d;
            hold_q <= hold_d;
            pend_q <= pend_d;
        end
    end

    // A pending word and a partial word never coexist: the byte that starts
    // a new partial word is the same byte that releases the pending one.
    always_comb begin
        ptr_d       = ptr_q;
        asm_d       = asm_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        emit_o      = 1'b0;
        emit_data_o = 56'h0;
        emit_keep_o = 8'h0;
        if (flush_i) begin
            if (ptr_q != 3'd0) begin
                emit_o      = 1'b1;
                emit_data_o = asm_q;
                emit_keep_o = lane_keep(ptr_q);
            end else if (pend_q) begin
                emit_o      = 1'b1;
                emit_data_o = hold_q;
                emit_keep_o = 8'hFF;
            end
            ptr_d  = 3'd0;
            asm_d  = 56'h0;
            hold_d = 56'h0;
            pend_d = 1'b0;
        end else if (wr_en_i) begin
            if (pend_q) begin
                emit_o      = 1'b1;
                emit_data_o = hold_q;
                emit_keep_o = 8'hFF;
                pend_d      = 1'b0;
            end
            if (ptr_q == 3'(PAYLOAD_LANES - 1)) begin
                hold_d = {wr_byte_i, asm_q[47:0]};
                pend_d = 1'b1;
                asm_d  = 56'h0;
                ptr_d  = 3'd0;
            end else begin
                asm_d[{ptr_q, 3'b000} +: 8] = wr_byte_i;
                ptr_d = ptr_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/gmii_to_axis_rx.sv
// GMII receive to 64-bit AXI-Stream converter: 7 payload bytes per beat plus a
// tag byte in lane 0. Define GMII_PREAMBLE_STRIP_EN to strip preamble and SFD.
module gmii_to_axis_rx
    import gmii_axis_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 1522
) (
    input  logic               gmii_rx_clk,
    input  logic               rst_n,
    gmii_to_axis_rx_if.slave   bus,
    output rx_state_e          dbg_state_o
);

    localparam int CW = $clog2(MAX_FRAME_LEN + 2);

    rx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        sop_q, sop_d;
    logic        boot_q;

    logic        tvalid_q, tvalid_d;
    logic [63:0] tdata_q,  tdata_d;
    logic [7:0]  tkeep_q,  tkeep_d;
    logic        tlast_q,  tlast_d;

    logic        pk_wr_en;
    logic        pk_flush;
    logic        pk_emit;
    logic [55:0] pk_data;
    logic [7:0]  pk_keep;
    logic        eop;
    logic [7:0]  tag;

    gmii_rx_byte_packer u_packer (
        .gmii_rx_clk (gmii_rx_clk),
        .rst_n       (rst_n),
        .wr_en_i     (pk_wr_en),
        .wr_byte_i   (bus.gmii_rxd),
        .flush_i     (pk_flush),
        .emit_o      (pk_emit),
        .emit_data_o (pk_data),
        .emit_keep_o (pk_keep)
    );

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // boot_q is only high in the first cycle after reset, so a frame already
    // in flight when reset lifts is swallowed rather than emitted headless.
    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            err_q    <= 1'b0;
            sop_q    <= 1'b0;
            boot_q   <= 1'b1;
            tvalid_q <= 1'b0;
            tdata_q  <= 64'h0;
            tkeep_q  <= 8'h0;
            tlast_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            sop_q    <= sop_d;
            boot_q   <= 1'b0;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        sop_d    = sop_q;
        pk_wr_en = 1'b0;
        pk_flush = 1'b0;
        eop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.gmii_rx_dv) begin
                    if (boot_q) begin
                        state_d = DROP_SILENT;
                    end else begin
                        sop_d = 1'b1;
                        err_d = bus.gmii_rx_er;
`ifdef GMII_PREAMBLE_STRIP_EN
                        state_d = PRE;
`else
                        state_d  = DATA;
                        pk_wr_en = 1'b1;
                        cnt_d    = CW'(1);
`endif
                    end
                end
            end
`ifdef GMII_PREAMBLE_STRIP_EN
            PRE: begin
                if (!bus.gmii_rx_dv) begin
                    state_d = IDLE;
                end else begin
                    err_d = err_q | bus.gmii_rx_er;
                    if (bus.gmii_rxd == GMII_SFD) state_d = DATA;
                end
            end
`endif
            DATA: begin
                if (!bus.gmii_rx_dv) begin
                    pk_flush = 1'b1;
                    eop      = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == CW'(MAX_FRAME_LEN)) begin
                    state_d = DROP;
                    err_d   = 1'b1;
                end else begin
                    err_d    = err_q | bus.gmii_rx_er;
                    pk_wr_en = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            DROP: begin
                if (!bus.gmii_rx_dv) begin
                    pk_flush = 1'b1;
                    eop      = 1'b1;
                    state_d  = IDLE;
                end
            end
            DROP_SILENT: begin
                if (!bus.gmii_rx_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) cnt_d = '0;

        tag          = 8'h0;
        tag[TAG_SOP] = sop_q;
        tag[TAG_EOP] = eop;
        tag[TAG_ERR] = eop & err_q;

        tvalid_d = 1'b0;
        tdata_d  = 64'h0;
        tkeep_d  = 8'h0;
        tlast_d  = 1'b0;
        if (pk_emit) begin
            tvalid_d = 1'b1;
            tdata_d  = {pk_data, tag};
            tkeep_d  = pk_keep;
            tlast_d  = eop;
            sop_d    = 1'b0;
        end
    end

    assign bus.axis_tvalid = tvalid_q;
    assign bus.axis_tdata  = tdata_q;
    assign bus.axis_tkeep  = tkeep_q;
    assign bus.axis_tlast  = tlast_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_gmii_to_axis_rx.sv
// Directed bench for gmii_to_axis_rx: a default instance and one with MAX_FRAME_LEN=16
// share the same GMII stimulus; beats are captured per instance and checked per test.
module tb_gmii_to_axis_rx;
  import gmii_axis_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    int          cyc;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic       dv;
  logic       er;
  logic [7:0] rxd;
  rx_state_e  state_a;
  rx_state_e  state_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_cyc = 0;
  int drop_cyc = 0;
  int idle_bad = 0;
  int adj_bad = 0;
  logic prev_a = 1'b0;
  logic prev_s = 1'b0;

  logic [7:0] fb [0:63];
  beat_t q_a[$];
  beat_t q_s[$];
  beat_t b;

  gmii_to_axis_rx_if if_a ();
  gmii_to_axis_rx_if if_s ();

  assign if_a.gmii_rx_dv = dv;
  assign if_a.gmii_rx_er = er;
  assign if_a.gmii_rxd   = rxd;
  assign if_s.gmii_rx_dv = dv;
  assign if_s.gmii_rx_er = er;
  assign if_s.gmii_rxd   = rxd;

  gmii_to_axis_rx #(.MAX_FRAME_LEN(1522)) dut_a (
    .gmii_rx_clk (clk),
    .rst_n       (rst_n),
    .bus         (if_a),
    .dbg_state_o (state_a)
  );

  gmii_to_axis_rx #(.MAX_FRAME_LEN(16)) dut_s (
    .gmii_rx_clk (clk),
    .rst_n       (rst_n),
    .bus         (if_s),
    .dbg_state_o (state_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #4 clk = ~clk;
  always @(posedge clk) cyc++;

  // beat capture and idle-bus monitoring
  always @(negedge clk) begin
    if (if_a.axis_tvalid) q_a.push_back('{data: if_a.axis_tdata, keep: if_a.axis_tkeep, last: if_a.axis_tlast, cyc: cyc});
    else if (if_a.axis_tdata != 64'h0 || if_a.axis_tkeep != 8'h0 || if_a.axis_tlast) idle_bad++;
    if (if_s.axis_tvalid) q_s.push_back('{data: if_s.axis_tdata, keep: if_s.axis_tkeep, last: if_s.axis_tlast, cyc: cyc});
    else if (if_s.axis_tdata != 64'h0 || if_s.axis_tkeep != 8'h0 || if_s.axis_tlast) idle_bad++;
    if ((prev_a && if_a.axis_tvalid) || (prev_s && if_s.axis_tvalid)) adj_bad++;
    prev_a = if_a.axis_tvalid;
    prev_s = if_s.axis_tvalid;
  end

  // driver tasks
  task automatic fill(input logic [7:0] start, input int len);
    for (int i = 0; i < len; i++) fb[i] = start + 8'(i);
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic e);
    @(negedge clk);
    dv = 1'b1; rxd = d; er = e;
  endtask

  task automatic send_frame(input int len, input int er_idx, input int gap, input bit raw);
`ifdef GMII_PREAMBLE_STRIP_EN
    if (!raw) begin
      for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b0);
      drive_byte(GMII_SFD, 1'b0);
    end
`endif
    for (int i = 0; i < len; i++) begin
      drive_byte(fb[i], (i == er_idx));
      if (i == 0) first_cyc = cyc + 1;
    end
    @(negedge clk);
    dv = 1'b0; rxd = 8'h0; er = 1'b0;
    drop_cyc = cyc + 1;
    for (int i = 1; i < gap; i++) @(negedge clk);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    #1;
  endtask

  // tests
  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (if_a.axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", if_a.axis_tvalid); end
    checks++; if (if_a.axis_tdata !== 64'h0) begin errors++; $display("FAIL reset_tdata got %h exp 0", if_a.axis_tdata); end
    checks++; if (if_a.axis_tkeep !== 8'h0) begin errors++; $display("FAIL reset_tkeep got %h exp 00", if_a.axis_tkeep); end
    checks++; if (if_a.axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", if_a.axis_tlast); end
    checks++; if (state_a !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state_a, IDLE); end
    checks++; if (if_s.axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid_s got %b exp 0", if_s.axis_tvalid); end
  endtask

  task automatic test_two_beats();
    q_a.delete(); q_s.delete();
    fill(8'h01, 14);
    send_frame(14, -1, 3, 1'b0);
    settle();
    checks++; if (q_a.size() !== 2) begin errors++; $display("FAIL f14_count got %0d exp 2", q_a.size()); end
    b = (q_a.size() > 0) ? q_a[0] : '0;
    checks++; if (b.data !== 64'h0706050403020101) begin errors++; $display("FAIL f14_b0_data got %h exp 0706050403020101", b.data); end
    checks++; if (b.keep !== 8'hFF || b.last !== 1'b0) begin errors++; $display("FAIL f14_b0_keep_last got %h/%b exp ff/0", b.keep, b.last); end
    checks++; if (b.cyc !== first_cyc + 7) begin errors++; $display("FAIL f14_b0_timing got %0d exp %0d", b.cyc, first_cyc + 7); end
    b = (q_a.size() > 1) ? q_a[1] : '0;
    checks++; if (b.data !== 64'h0E0D0C0B0A090802) begin errors++; $display("FAIL f14_b1_data got %h exp 0e0d0c0b0a090802", b.data); end
    checks++; if (b.keep !== 8'hFF || b.last !== 1'b1) begin errors++; $display("FAIL f14_b1_keep_last got %h/%b exp ff/1", b.keep, b.last); end
    checks++; if (b.cyc !== drop_cyc) begin errors++; $display("FAIL f14_b1_timing got %0d exp %0d", b.cyc, drop_cyc); end
  endtask

  task automatic test_partial();
    q_a.delete(); q_s.delete();
    fill(8'h01, 10);
    send_frame(10, -1, 3, 1'b0);
    settle();
    checks++; if (q_a.size() !== 2) begin errors++; $display("FAIL f10_count got %0d exp 2", q_a.size()); end
    b = (q_a.size() > 1) ? q_a[1] : '0;
    checks++; if (b.data !== 64'h000000000A090802) begin errors++; $display("FAIL f10_b1_data got %h exp 000000000a090802", b.data); end
    checks++; if (b.keep !== 8'h0F || b.last !== 1'b1) begin errors++; $display("FAIL f10_b1_keep_last got %h/%b exp 0f/1", b.keep, b.last); end
    q_a.delete(); q_s.delete();
    fill(8'h00, 11);
    send_frame(11, -1, 3, 1'b0);
    settle();
    b = (q_a.size() > 0) ? q_a[0] : '0;
    checks++; if (b.data !== 64'h0605040302010001) begin errors++; $display("FAIL f11_b0_data got %h exp 0605040302010001", b.data); end
    b = (q_a.size() > 1) ? q_a[1] : '0;
    checks++; if (b.data[39:8] !== 32'h0A090807) begin errors++; $display("FAIL f11_b1_lanes got %h exp 0a090807", b.data[39:8]); end
    checks++; if (b.data !== 64'h0000000A09080702 || b.keep !== 8'h1F) begin errors++; $display("FAIL f11_b1_data_keep got %h/%h exp 0000000a09080702/1f", b.data, b.keep); end
  endtask

  task automatic test_preamble();
    q_a.delete(); q_s.delete();
    for (int i = 0; i < 7; i++) fb[i] = 8'h55;
    fb[7] = 8'hD5;
    fb[8] = 8'hAA;
    send_frame(9, -1, 3, 1'b1);
    settle();
`ifdef GMII_PREAMBLE_STRIP_EN
    checks++; if (q_a.size() !== 1) begin errors++; $display("FAIL pre_count got %0d exp 1", q_a.size()); end
    b = (q_a.size() > 0) ? q_a[0] : '0;
    checks++; if (b.data !== 64'h000000000000AA03) begin errors++; $display("FAIL pre_data got %h exp 000000000000aa03", b.data); end
    checks++; if (b.keep !== 8'h03 || b.last !== 1'b1) begin errors++; $display("FAIL pre_keep_last got %h/%b exp 03/1", b.keep, b.last); end
    q_a.delete(); q_s.delete();
    for (int i = 0; i < 6; i++) fb[i] = 8'h55;
    send_frame(6, -1, 3, 1'b1);
    fb[0] = 8'h55; fb[1] = 8'hD5;
    send_frame(2, -1, 3, 1'b1);
    settle();
    checks++; if (q_a.size() !== 0) begin errors++; $display("FAIL pre_nosfd_empty got %0d exp 0", q_a.size()); end
`else
    checks++; if (q_a.size() !== 2) begin errors++; $display("FAIL pre_count got %0d exp 2", q_a.size()); end
    b = (q_a.size() > 0) ? q_a[0] : '0;
    checks++; if (b.data !== 64'h5555555555555501 || b.keep !== 8'hFF) begin errors++; $display("FAIL pre_b0 got %h/%h exp 5555555555555501/ff", b.data, b.keep); end
    b = (q_a.size() > 1) ? q_a[1] : '0;
    checks++; if (b.data !== 64'h0000000000AAD502) begin errors++; $display("FAIL pre_b1_data got %h exp 0000000000aad502", b.data); end
    checks++; if (b.keep !== 8'h07 || b.last !== 1'b1) begin errors++; $display("FAIL pre_b1_keep_last got %h/%b exp 07/1", b.keep, b.last); end
`endif
  endtask

  task automatic test_rx_error();
    q_a.delete(); q_s.delete();
    fill(8'h01, 20);
    send_frame(20, 2, 3, 1'b0);
    settle();
    checks++; if (q_a.size() !== 3) begin errors++; $display("FAIL err_count got %0d exp 3", q_a.size()); end
    b = (q_a.size() > 0) ? q_a[0] : '0;
    checks++; if (b.data !== 64'h0706050403020101) begin errors++; $display("FAIL err_b0 got %h exp 0706050403020101", b.data); end
    b = (q_a.size() > 1) ? q_a[1] : '0;
    checks++; if (b.data[7:0] !== 8'h00 || b.last !== 1'b0) begin errors++; $display("FAIL err_b1_tag got %h/%b exp 00/0", b.data[7:0], b.last); end
    b = (q_a.size() > 2) ? q_a[2] : '0;
    checks++; if (b.data !== 64'h0014131211100F06) begin errors++; $display("FAIL err_b2_data got %h exp 0014131211100f06", b.data); end
    checks++; if (b.keep !== 8'h7F || b.last !== 1'b1) begin errors++; $display("FAIL err_b2_keep_last got %h/%b exp 7f/1", b.keep, b.last); end
  endtask

  task automatic test_max_len();
    q_a.delete(); q_s.delete();
    fill(8'h01, 30);
    send_frame(30, -1, 3, 1'b0);
    settle();
    checks++; if (q_s.size() !== 3) begin errors++; $display("FAIL max_count got %0d exp 3", q_s.size()); end
    b = (q_s.size() > 0) ? q_s[0] : '0;
    checks++; if (b.data !== 64'h0706050403020101 || b.keep !== 8'hFF) begin errors++; $display("FAIL max_b0 got %h/%h exp 0706050403020101/ff", b.data, b.keep); end
    b = (q_s.size() > 1) ? q_s[1] : '0;
    checks++; if (b.data !== 64'h0E0D0C0B0A090800 || b.last !== 1'b0) begin errors++; $display("FAIL max_b1 got %h/%b exp 0e0d0c0b0a090800/0", b.data, b.last); end
    b = (q_s.size() > 2) ? q_s[2] : '0;
    checks++; if (b.data !== 64'h0000000000100F06) begin errors++; $display("FAIL max_b2_data got %h exp 0000000000100f06", b.data); end
    checks++; if (b.keep !== 8'h07 || b.last !== 1'b1) begin errors++; $display("FAIL max_b2_keep_last got %h/%b exp 07/1", b.keep, b.last); end
    checks++; if (b.cyc !== drop_cyc) begin errors++; $display("FAIL max_b2_timing got %0d exp %0d", b.cyc, drop_cyc); end
    b = (q_a.size() > 4) ? q_a[4] : '0;
    checks++; if (q_a.size() !== 5 || b.data !== 64'h00000000001E1D02) begin errors++; $display("FAIL max_default_last got %0d/%h exp 5/00000000001e1d02", q_a.size(), b.data); end
    q_a.delete(); q_s.delete();
    fill(8'h01, 16);
    send_frame(16, -1, 3, 1'b0);
    settle();
    b = (q_s.size() > 2) ? q_s[2] : '0;
    checks++; if (q_s.size() !== 3 || b.data !== 64'h0000000000100F02) begin errors++; $display("FAIL max_exact got %0d/%h exp 3/0000000000100f02", q_s.size(), b.data); end
  endtask

  task automatic test_back_to_back();
    int drop_first;
    q_a.delete(); q_s.delete();
    fill(8'hA1, 7);
    send_frame(7, -1, 1, 1'b0);
    drop_first = drop_cyc;
    fill(8'hB1, 3);
    send_frame(3, -1, 3, 1'b0);
    settle();
    checks++; if (q_a.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", q_a.size()); end
    b = (q_a.size() > 0) ? q_a[0] : '0;
    checks++; if (b.data !== 64'hA7A6A5A4A3A2A103 || b.keep !== 8'hFF || b.last !== 1'b1) begin errors++; $display("FAIL b2b_b0 got %h/%h/%b exp a7a6a5a4a3a2a103/ff/1", b.data, b.keep, b.last); end
    checks++; if (b.cyc !== drop_first) begin errors++; $display("FAIL b2b_b0_timing got %0d exp %0d", b.cyc, drop_first); end
    b = (q_a.size() > 1) ? q_a[1] : '0;
    checks++; if (b.data !== 64'h00000000B3B2B103 || b.keep !== 8'h0F) begin errors++; $display("FAIL b2b_b1 got %h/%h exp 00000000b3b2b103/0f", b.data, b.keep); end
    checks++; if (b.cyc !== drop_cyc) begin errors++; $display("FAIL b2b_b1_timing got %0d exp %0d", b.cyc, drop_cyc); end
  endtask

  task automatic test_reset_mid();
    q_a.delete(); q_s.delete();
    fill(8'h01, 12);
    for (int i = 0; i < 12; i++) begin
      drive_byte(fb[i], 1'b0);
      if (i == 4) begin
        rst_n = 1'b0;
        #1;
        checks++; if (state_a !== IDLE || if_a.axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_clear got %0d/%b exp %0d/0", state_a, if_a.axis_tvalid, IDLE); end
      end
      if (i == 5) rst_n = 1'b1;
      if (i == 8) begin
        checks++; if (state_a !== DROP_SILENT) begin errors++; $display("FAIL rstmid_silent got %0d exp %0d", state_a, DROP_SILENT); end
      end
    end
    @(negedge clk);
    dv = 1'b0; rxd = 8'h0;
    settle();
    checks++; if (q_a.size() !== 0 || q_s.size() !== 0) begin errors++; $display("FAIL rstmid_no_output got %0d/%0d exp 0/0", q_a.size(), q_s.size()); end
    fill(8'h21, 3);
    send_frame(3, -1, 3, 1'b0);
    settle();
    b = (q_a.size() > 0) ? q_a[0] : '0;
    checks++; if (q_a.size() !== 1 || b.data !== 64'h0000000023222103 || b.keep !== 8'h0F) begin errors++; $display("FAIL rstmid_next got %0d/%h/%h exp 1/0000000023222103/0f", q_a.size(), b.data, b.keep); end
  endtask

  task automatic test_idle_bus();
    checks++; if (idle_bad !== 0) begin errors++; $display("FAIL idle_bus_zero got %0d exp 0", idle_bad); end
    checks++; if (adj_bad !== 0) begin errors++; $display("FAIL tvalid_single_cycle got %0d exp 0", adj_bad); end
  endtask

  initial begin
    rst_n = 1'b0;
    dv = 1'b0;
    er = 1'b0;
    rxd = 8'h0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_two_beats();
    test_partial();
    test_preamble();
    test_rx_error();
    test_max_len();
    test_back_to_back();
    test_reset_mid();
    test_idle_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
